sw_bounce_gen: RTL and testbench

- Generates a mechanically realistic, bouncy switch signal from a clean level request.
- Sits on the drive side of the switch debouncer and provides its `sw` input in on-chip self-test and in gate-level loopback runs.
- On each requested level change, `sw_out` toggles pseudo-randomly for a programmable window, then settles to the requested level.
- A bypass mode passes the level through directly.

---
 rtl/sw_bounce_gen_if.sv | 30 +++
 rtl/sw_bounce_gen.sv | 139 +++++++++++++
 tb/tb_sw_bounce_gen.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/sw_bounce_gen_if.sv
// rtl/sw_bounce_gen_if.sv - signal bundle between a bounce emulator and its driver/consumer
//
// level_in : clean requested switch level (driver -> emulator)
// en       : 1 = bounce emulation, 0 = bypass (driver -> emulator)
// sw_out   : emulated bouncy switch signal (emulator -> consumer)
// busy     : bounce window in progress (emulator -> consumer)
// done     : one-cycle pulse when sw_out settles (emulator -> consumer)
interface sw_bounce_gen_if;
    logic level_in;
    logic en;
    logic sw_out;
    logic busy;
    logic done;

    modport master (
        output level_in,
        output en,
        input  sw_out,
        input  busy,
        input  done
    );

    modport slave (
        input  level_in,
        input  en,
        output sw_out,
        output busy,
        output done
    );
endinterface

// File: rtl/sw_bounce_gen.sv
// rtl/sw_bounce_gen.sv - bouncy switch emulator driven from a clean level request
//
// clk   : system clock, rising edge
// rst_n : asynchronous active-low reset
// bus   : slave side of sw_bounce_gen_if (level_in, en in; sw_out, busy, done out, all registered)
module sw_bounce_gen #(
    parameter int unsigned CW          = 24,
    parameter int unsigned BOUNCE_CYC  = 262144,
    parameter int unsigned GLITCH_LOG2 = 4,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic            clk,
    input  logic            rst_n,
    sw_bounce_gen_if.slave  bus
);

    localparam logic [CW-1:0] WIN_LAST = CW'(BOUNCE_CYC - 1);
    // Low GLITCH_LOG2 bits of the counter; a new random sample is taken when they wrap to zero.
    localparam logic [CW-1:0] GMASK    = CW'((64'd1 << GLITCH_LOG2) - 64'd1);

    typedef enum logic {
        IDLE   = 1'b0,
        BOUNCE = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic          lvl, lvl_nxt;
    logic          target, target_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [CW-1:0] cnt_dec;
    logic [15:0]   lfsr, lfsr_nxt;
    logic          sw, sw_nxt;
    logic          busy_r, busy_nxt;
    logic          done_r, done_nxt;
    logic          level_in;
    logic          en;

    assign level_in = bus.level_in;
    assign en       = bus.en;
    assign cnt_dec  = cnt - 1'b1;

    // Fibonacci LFSR, taps 16,14,13,11; free-running so the bounce pattern differs per window.
    assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            lvl    <= 1'b0;
            target <= 1'b0;
            cnt    <= '0;
            lfsr   <= LFSR_SEED;
            sw     <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            lvl    <= lvl_nxt;
            target <= target_nxt;
            cnt    <= cnt_nxt;
            lfsr   <= lfsr_nxt;
            sw     <= sw_nxt;
            busy_r <= busy_nxt;
            done_r <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (en && (level_in != lvl)) begin
                    state_nxt = BOUNCE;
                end
            end
            BOUNCE: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (level_in != target) begin
                    state_nxt = BOUNCE;
                end else if (cnt == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        lvl_nxt    = lvl;
        target_nxt = target;
        cnt_nxt    = cnt;
        sw_nxt     = sw;
        busy_nxt   = busy_r;
        done_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (!en) begin
                    lvl_nxt = level_in;
                    sw_nxt  = level_in;
                end else if (level_in != lvl) begin
                    target_nxt = level_in;
                    cnt_nxt    = WIN_LAST;
                    busy_nxt   = 1'b1;
                    sw_nxt     = lfsr[0];
                end
            end
            BOUNCE: begin
                if (!en) begin
                    sw_nxt   = level_in;
                    lvl_nxt  = level_in;
                    busy_nxt = 1'b0;
                end else if (level_in != target) begin
                    // Request changed mid-window (possibly back to lvl): restart a full window.
                    target_nxt = level_in;
                    cnt_nxt    = WIN_LAST;
                    sw_nxt     = lfsr[0];
                end else if (cnt == '0) begin
                    sw_nxt   = target;
                    lvl_nxt  = target;
                    busy_nxt = 1'b0;
                    done_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_dec;
                    if ((cnt_dec & GMASK) == '0) begin
                        sw_nxt = lfsr[0];
                    end
                end
            end
            default: begin
                busy_nxt = 1'b0;
            end
        endcase
    end

    assign bus.sw_out = sw;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;

endmodule

// File: tb/tb_sw_bounce_gen.sv
// tb/tb_sw_bounce_gen.sv - directed self-checking bench for sw_bounce_gen
module tb_sw_bounce_gen;

    localparam logic [15:0] SEED = 16'hACE1;

    logic clk;
    logic rst_n;

    sw_bounce_gen_if bus();

    sw_bounce_gen #(
        .CW          (24),
        .BOUNCE_CYC  (64),
        .GLITCH_LOG2 (2),
        .LFSR_SEED   (SEED)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    logic [15:0] m_lfsr;
    logic [15:0] lf_prev;
    logic        exp_sw;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // One clock: lf_prev is the LFSR value the DUT sees at this edge.
    task automatic tick();
        lf_prev = m_lfsr;
        @(posedge clk);
        if (rst_n) m_lfsr = lfsr_adv(m_lfsr);
        else       m_lfsr = SEED;
        #1;
    endtask

    task automatic outs(input string tag, input logic s, input logic b, input logic d);
        check({tag, ".sw"},   {31'd0, bus.sw_out}, {31'd0, s});
        check({tag, ".busy"}, {31'd0, bus.busy},   {31'd0, b});
        check({tag, ".done"}, {31'd0, bus.done},   {31'd0, d});
    endtask

    // Trigger edge: sw_out takes the current LFSR bit, busy rises.
    task automatic trigger(input string tag);
        tick();
        exp_sw = lf_prev[0];
        outs(tag, exp_sw, 1'b1, 1'b0);
    endtask

    // Window steps k (edges after trigger). With 64-cycle window and 4-cycle hold,
    // new samples land on k = 3, 7, 11, ..., 63.
    task automatic steps(input string tag, input int k_from, input int k_to);
        for (int k = k_from; k <= k_to; k++) begin
            tick();
            if ((k % 4) == 3) exp_sw = lf_prev[0];
            outs(tag, exp_sw, 1'b1, 1'b0);
        end
    endtask

    task automatic settle(input string tag, input logic tgt);
        tick();
        outs({tag, ".settle"}, tgt, 1'b0, 1'b1);
        tick();
        outs({tag, ".after"}, tgt, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        m_lfsr       = SEED;
        rst_n        = 1'b0;
        bus.level_in = 1'b1;
        bus.en       = 1'b1;

        // Reset held 5 cycles with a pending level request.
        for (int i = 0; i < 5; i++) tick();
        outs("reset", 1'b0, 1'b0, 1'b0);
        check("reset.lfsr", {16'd0, dut.lfsr}, {16'd0, SEED});

        // Release: window starts on the very first edge.
        rst_n = 1'b1;
        trigger("rel_trig");
        steps("rel_win", 1, 63);
        settle("rel", 1'b1);

        // Bypass: 0 -> 1 -> 0, 3-cycle spacing.
        bus.en       = 1'b0;
        bus.level_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            outs("byp0", 1'b0, 1'b0, 1'b0);
        end
        bus.level_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            outs("byp1", 1'b1, 1'b0, 1'b0);
        end
        bus.level_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            outs("byp2", 1'b0, 1'b0, 1'b0);
        end

        // Enabled with no level change: nothing moves.
        bus.en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            outs("quiet", 1'b0, 1'b0, 1'b0);
        end

        // Normal press 0 -> 1.
        bus.level_in = 1'b1;
        trigger("press_trig");
        steps("press_win", 1, 63);
        settle("press", 1'b1);

        // Back to 0 via bypass, then re-trigger test.
        bus.en       = 1'b0;
        bus.level_in = 1'b0;
        tick();
        outs("rt_prep", 1'b0, 1'b0, 1'b0);
        bus.en = 1'b1;
        tick();
        outs("rt_idle", 1'b0, 1'b0, 1'b0);
        bus.level_in = 1'b1;
        trigger("rt_trig");
        steps("rt_win1", 1, 29);
        bus.level_in = 1'b0;
        trigger("rt_retrig");
        steps("rt_win2", 1, 63);
        settle("rt", 1'b0);

        // Abort: en drops at E0+10 with level_in=1.
        bus.level_in = 1'b1;
        trigger("ab_trig");
        steps("ab_win", 1, 9);
        bus.en = 1'b0;
        tick();
        outs("abort", 1'b1, 1'b0, 1'b0);
        tick();
        outs("abort.after", 1'b1, 1'b0, 1'b0);

        // Async reset mid-window (lvl is 1, request 0).
        bus.en       = 1'b1;
        bus.level_in = 1'b0;
        trigger("ar_trig");
        steps("ar_win", 1, 19);
        #2;
        rst_n  = 1'b0;
        m_lfsr = SEED;
        #1;
        outs("async_rst", 1'b0, 1'b0, 1'b0);
        check("async_rst.lfsr", {16'd0, dut.lfsr}, {16'd0, SEED});
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        outs("ar_rel", 1'b0, 1'b0, 1'b0);
        // LFSR restarted from the seed: the next window follows the model from SEED.
        bus.level_in = 1'b1;
        trigger("ar2_trig");
        steps("ar2_win", 1, 63);
        settle("ar2", 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
